// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - snapshots nine MAC results and streams the valid rows x cols block out row-major.
// Optional RESULT_PARITY_EN adds data_parity (even parity of data_out).
module result_unloader #(
   parameter int RES_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               unload_res,
   input  logic [1:0]         row_w,
   input  logic [1:0]         col_x,
   input  logic [9*RES_W-1:0] mac_res,
   output logic [RES_W-1:0]   data_out,
   output logic               data_valid,
   input  logic               data_ready,
   output logic [1:0]         elem_row,
   output logic [1:0]         elem_col,
   output logic               done,
   output logic               clear_mem
`ifdef RESULT_PARITY_EN
   ,
   output logic               data_parity
`endif
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t               state, state_d;
   logic                 unload_res_q;
   logic [9*RES_W-1:0]   snap;
   logic [1:0]           rows_q, cols_q;
   logic [1:0]           r_nx, c_nx;
   logic [3:0]           idx_nx;
   logic [RES_W-1:0]     word_nx;
   logic                 start, xfer, last;
   logic                 parity_q;

   assign start      = unload_res & ~unload_res_q;
   assign data_valid = (state == STREAM);
   assign done       = (state == DONE);
   assign clear_mem  = (state == DONE);
   assign xfer       = data_valid & data_ready;
   // elem_row/elem_col double as the stream index registers
   assign last       = (elem_row == rows_q - 2'd1) && (elem_col == cols_q - 2'd1);

   always_comb begin
      r_nx    = elem_row;
      c_nx    = elem_col + 2'd1;
      if (elem_col == cols_q - 2'd1) begin
         c_nx = 2'd0;
         r_nx = elem_row + 2'd1;
      end
      idx_nx  = {2'b00, r_nx} * 4'd3 + {2'b00, c_nx};
      word_nx = '0;
      for (int k = 0; k < 9; k++) begin
         if (idx_nx == 4'(k)) word_nx = snap[k*RES_W +: RES_W];
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = (row_w == 2'd0 || col_x == 2'd0) ? DONE : STREAM;
         STREAM:  if (xfer && last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         unload_res_q <= 1'b0;
         snap         <= '0;
         rows_q       <= 2'd0;
         cols_q       <= 2'd0;
         data_out     <= '0;
         elem_row     <= 2'd0;
         elem_col     <= 2'd0;
         parity_q     <= 1'b0;
      end else begin
         state        <= state_d;
         unload_res_q <= unload_res;
         if (state == IDLE && start) begin
            snap     <= mac_res;
            rows_q   <= row_w;
            cols_q   <= col_x;
            data_out <= mac_res[RES_W-1:0];
            parity_q <= ^mac_res[RES_W-1:0];
            elem_row <= 2'd0;
            elem_col <= 2'd0;
         end else if (xfer && !last) begin
            data_out <= word_nx;
            parity_q <= ^word_nx;
            elem_row <= r_nx;
            elem_col <= c_nx;
         end
      end
   end

`ifdef RESULT_PARITY_EN
   assign data_parity = parity_q;
`else
   logic unused_parity;
   assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - table-driven self-checking bench for result_unloader.
module tb_result_unloader;
   localparam int RES_W = 10;

   logic               clk = 1'b0;
   logic               rst, unload_res, data_ready;
   logic [1:0]         row_w, col_x;
   logic [9*RES_W-1:0] mac_res;
   logic [RES_W-1:0]   data_out;
   logic               data_valid, done, clear_mem;
   logic [1:0]         elem_row, elem_col;
`ifdef RESULT_PARITY_EN
   logic               data_parity;
`endif

   result_unloader #(.RES_W(RES_W)) dut (
      .clk(clk), .rst(rst), .unload_res(unload_res), .row_w(row_w), .col_x(col_x),
      .mac_res(mac_res), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .elem_row(elem_row), .elem_col(elem_col),
      .done(done), .clear_mem(clear_mem)
`ifdef RESULT_PARITY_EN
      , .data_parity(data_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int rows;
      int cols;
      bit stall;
      int n;
   } vec_t;

   int               errors = 0;
   int               checks = 0;
   logic [RES_W-1:0] mac_word [9];
   vec_t             vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_mac;
      for (int k = 0; k < 9; k++) mac_res[k*RES_W +: RES_W] = mac_word[k];
   endtask

   task automatic run(input int rows, input int cols, input bit stall, input int n);
      int               beats, last_x, er, ec;
      bit               held, seen_done;
      logic [RES_W-1:0] hd;
      logic [1:0]       hr, hc;
      @(negedge clk);
      load_mac();
      row_w = 2'(rows); col_x = 2'(cols); unload_res = 1'b1; data_ready = 1'b0;
      @(negedge clk);
      unload_res = 1'b0;
      beats = 0; last_x = -1; er = 0; ec = 0; held = 0; seen_done = 0;
      hd = '0; hr = '0; hc = '0;
      for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (held) begin
            chk("stall_data", data_out, hd);
            chk("stall_row", elem_row, hr);
            chk("stall_col", elem_col, hc);
         end
         if (done) begin
            seen_done = 1;
            chk("done_timing", cyc, last_x + 1);
            chk("beat_count", beats, n);
            chk("clear_mem", clear_mem, 1);
            chk("valid_in_done", data_valid, 0);
         end else begin
            data_ready = stall ? (cyc % 3 == 0) : 1'b1;
            held = data_valid && !data_ready;
            if (held) begin
               hd = data_out; hr = elem_row; hc = elem_col;
            end
            if (data_valid && data_ready) begin
               chk("beat_data", data_out, mac_word[(er*3+ec) % 9]);
               chk("beat_row", elem_row, er);
               chk("beat_col", elem_col, ec);
`ifdef RESULT_PARITY_EN
               chk("beat_parity", data_parity, ^mac_word[(er*3+ec) % 9]);
`endif
               beats++;
               last_x = cyc;
               if (ec == cols - 1) begin ec = 0; er++; end
               else ec++;
            end
         end
      end
      if (!seen_done) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("done_width", done, 0);
      chk("idle_valid", data_valid, 0);
      data_ready = 1'b0;
   endtask

   initial begin
      int beats, dones;
      vecs[0] = '{3, 3, 0, 9};
      vecs[1] = '{2, 3, 1, 6};
      vecs[2] = '{0, 2, 0, 0};
      vecs[3] = '{1, 3, 1, 3};
      vecs[4] = '{3, 1, 0, 3};
      vecs[5] = '{2, 2, 1, 4};
      vecs[6] = '{3, 0, 0, 0};
      for (int k = 0; k < 9; k++) mac_word[k] = RES_W'(k + 1);
      load_mac();
      rst = 1'b1; unload_res = 1'b0; data_ready = 1'b0; row_w = 2'd0; col_x = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_valid", data_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_row", elem_row, 0);
      chk("rst_col", elem_col, 0);
      chk("rst_done", done, 0);
      chk("rst_clear", clear_mem, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run(vecs[i].rows, vecs[i].cols, vecs[i].stall, vecs[i].n);

      // level held high: one run only
      mac_word[0] = 10'h2A5;
      @(negedge clk);
      load_mac();
      row_w = 2'd1; col_x = 2'd1; unload_res = 1'b1; data_ready = 1'b1;
      beats = 0; dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (data_valid && data_ready) begin
            beats++;
            chk("hold_data", data_out, 10'h2A5);
         end
         if (done) dones++;
      end
      chk("hold_beats", beats, 1);
      chk("hold_dones", dones, 1);
      unload_res = 1'b0;
      run(1, 1, 0, 1);
      mac_word[0] = 10'd1;

      // reset while stalled on the 4th beat
      @(negedge clk);
      load_mac();
      row_w = 2'd3; col_x = 2'd3; unload_res = 1'b1; data_ready = 1'b0;
      @(negedge clk);
      unload_res = 1'b0; data_ready = 1'b1;
      repeat (3) @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      chk("stall4_valid", data_valid, 1);
      chk("stall4_data", data_out, 4);
      chk("stall4_row", elem_row, 1);
      chk("stall4_col", elem_col, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", data_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_data", data_out, 0);
      rst = 1'b0;
      run(3, 3, 0, 9);

`ifdef RESULT_PARITY_EN
      mac_word[0] = 10'h003; mac_word[1] = 10'h007; mac_word[2] = 10'h000;
      run(1, 3, 0, 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
